fifo_sync_thresh: RTL and testbench
===================================

FIFO_SYNC_THRESH -- requirements
Module: fifo_sync_thresh

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 8, giving the number of entries (power of 2, at least 2).
REQ-002 The block SHALL have a parameter WIDTH, default 32, giving the data word width in bits.
REQ-003 The block SHALL have a parameter AF_LEVEL, default 6, giving the almost-full threshold (1 to DEPTH).
REQ-004 The block SHALL have a parameter AE_LEVEL, default 2, giving the almost-empty threshold (0 to DEPTH-1).
REQ-005 The block SHALL have the following ports, one per line: name, direction, width, meaning:
  clk  input  1  single clock; all state updates on its rising edge
  rst  input  1  synchronous, active-high reset
  wrEn  input  1  write request
  rdEn  input  1  read request
  dataIn  input  WIDTH  write data
  dataOut  output  WIDTH  read data
  full  output  1  count == DEPTH
  empty  output  1  count == 0
  almostFull  output  1  count >= AF_LEVEL
  almostEmpty  output  1  count <= AE_LEVEL
  count  output  $clog2(DEPTH)+1  current occupancy
  overflow  output  1  one-cycle pulse on a rejected write
  underflow  output  1  one-cycle pulse on a rejected read
REQ-006 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-007 A write SHALL be accepted when wrEn=1 and full=0; dataIn is stored at the write pointer, and the write pointer advances modulo DEPTH.
REQ-008 A read SHALL be accepted when rdEn=1 and empty=0; the read pointer advances modulo DEPTH.
REQ-009 Accept decisions SHALL use the pre-edge flags; a write at full SHALL be rejected even if a read is accepted in the same cycle, and a read at empty SHALL be rejected even if a write is accepted in the same cycle.
REQ-010 count SHALL be updated as follows: +1 on a write only, -1 on a read only, unchanged on both or neither; count SHALL never exceed DEPTH or go below 0.
REQ-011 full, empty, almostFull and almostEmpty SHALL be decoded from the registered count, so they are valid in the same cycle as count.
REQ-012 overflow SHALL be 1 for exactly the cycle after a rejected write (wrEn=1 while full=1), else 0.
REQ-013 underflow SHALL be 1 for exactly the cycle after a rejected read (rdEn=1 while empty=1), else 0.
REQ-014 A rejected access SHALL change no pointer, no memory location and no count.
REQ-015 In standard mode, dataOut SHALL be registered: it updates to the head word on the edge that accepts a read (one-cycle latency) and otherwise holds its value.
REQ-016 Data SHALL leave the block in write order across any number of pointer wrap-arounds.

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL clear both pointers, count, dataOut, overflow and underflow to 0, and rst SHALL take priority over wrEn and rdEn.
REQ-018 After reset the flags SHALL be empty=1, almostEmpty=1, full=0 and almostFull=0; memory contents SHALL NOT be cleared but SHALL be unreachable.
REQ-019 Reset mid-operation SHALL discard all stored entries; the first write after reset SHALL be the first word read.

Configuration
REQ-020 The block SHALL support a macro FIFO_SYNC_FWFT_EN; when it is defined, the block SHALL operate in first-word-fall-through mode.
REQ-021 In FWFT mode, dataOut SHALL equal the head entry whenever empty=0, valid the cycle after the write that made the FIFO non-empty, and SHALL be 0 when empty=1.
REQ-022 In FWFT mode, an accepted read SHALL consume the word currently shown, and the next head SHALL appear on the following cycle.
REQ-023 When FIFO_SYNC_FWFT_EN is not defined, the block SHALL operate in standard mode per REQ-015; all other behaviour SHALL be identical in both modes.

Verification (DEPTH=8, WIDTH=32, AF_LEVEL=6, AE_LEVEL=2)
REQ-024 The bench SHALL cover fill: reset, then write 1,2,4..128 -> count steps 1..8, almostEmpty drops after the 3rd write, almostFull rises after the 6th, full rises after the 8th; a 9th write of 0xDEAD -> overflow pulses 1 cycle and count stays 8.
REQ-025 The bench SHALL cover drain (standard mode): 8 reads -> dataOut 1,2..128 one cycle after each read, empty=1 after the 8th; a 9th read -> underflow pulses 1 cycle and dataOut holds 128.
REQ-026 The bench SHALL cover simultaneous access: at count=4 assert wrEn and rdEn for 3 cycles -> count stays 4 and order is preserved; wrEn and rdEn at full -> read accepted, write rejected, overflow=1, count=7.
REQ-027 The bench SHALL cover wrap-around: 20 interleaved write/read pairs with data 0..19 -> reads return 0..19 in order and count ends at 0.
REQ-028 The bench SHALL cover reset mid-operation: assert rst at count=5 -> next cycle count=0, empty=1, dataOut=0; then write 0x55 and read -> 0x55.
REQ-029 The bench SHALL cover FWFT mode (FIFO_SYNC_FWFT_EN defined): write 0xA5 with no rdEn -> dataOut=0xA5 the next cycle; a read -> empty=1 and dataOut=0.

Source files
------------

// File: rtl/fifo_sync_thresh.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and
// overflow/underflow pulses. Define FIFO_SYNC_FWFT_EN for first-word-fall-through output.
module fifo_sync_thresh #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 32,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wrEn,
   input  logic                       rdEn,
   input  logic [WIDTH-1:0]           dataIn,
   output logic [WIDTH-1:0]           dataOut,
   output logic                       full,
   output logic                       empty,
   output logic                       almostFull,
   output logic                       almostEmpty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_ovf, r_unf;
   logic             w_wr_ok, w_rd_ok;

   // Accept decisions come from the pre-edge flags only.
   assign w_wr_ok = wrEn && !full;
   assign w_rd_ok = rdEn && !empty;

   assign count       = r_count;
   assign full        = (r_count == CW'(DEPTH));
   assign empty       = (r_count == '0);
   assign almostFull  = (r_count >= CW'(AF_LEVEL));
   assign almostEmpty = (r_count <= CW'(AE_LEVEL));
   assign overflow    = r_ovf;
   assign underflow   = r_unf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_ovf <= wrEn && full;
         r_unf <= rdEn && empty;
         if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
         if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
         if (w_wr_ok && !w_rd_ok)      r_count <= r_count + 1'b1;
         else if (w_rd_ok && !w_wr_ok) r_count <= r_count - 1'b1;
      end
   end

   // Storage is never cleared; reset just makes old entries unreachable.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok) r_mem[r_wptr] <= dataIn;
   end

`ifdef FIFO_SYNC_FWFT_EN
   assign dataOut = empty ? '0 : r_mem[r_rptr];
`else
   logic [WIDTH-1:0] r_dout;

   always_ff @(posedge clk) begin
      if (rst)          r_dout <= '0;
      else if (w_rd_ok) r_dout <= r_mem[r_rptr];
   end

   assign dataOut = r_dout;
`endif

endmodule

// File: tb/tb_fifo_sync_thresh.sv
// Directed bench for fifo_sync_thresh (DEPTH=8, WIDTH=32, AF=6, AE=2); covers
// standard mode by default and FWFT mode when FIFO_SYNC_FWFT_EN is defined.
module tb_fifo_sync_thresh;
   logic        clk = 1'b0;
   logic        rst, wrEn, rdEn;
   logic [31:0] dataIn, dataOut;
   logic        full, empty, almostFull, almostEmpty, overflow, underflow;
   logic [3:0]  count;
   int          checks = 0;
   int          errors = 0;

   fifo_sync_thresh #(.DEPTH(8), .WIDTH(32), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .dataIn(dataIn),
      .dataOut(dataOut), .full(full), .empty(empty), .almostFull(almostFull),
      .almostEmpty(almostEmpty), .count(count), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; dataIn = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input logic [31:0] d);
      wrEn = 1'b1; dataIn = d;
      tick();
      wrEn = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 4'd0)        begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      checks++; if (almostEmpty !== 1'b1)  begin errors++; $display("FAIL reset_ae got %b exp 1", almostEmpty); end
      checks++; if (full !== 1'b0)         begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      checks++; if (almostFull !== 1'b0)   begin errors++; $display("FAIL reset_af got %b exp 0", almostFull); end
      checks++; if (dataOut !== 32'd0)     begin errors++; $display("FAIL reset_dout got %h exp 0", dataOut); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0)
         begin errors++; $display("FAIL reset_pulses got %b%b exp 00", overflow, underflow); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push(32'd1 << i);
         checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
         checks++; if (almostEmpty !== (i < 2)) begin errors++; $display("FAIL fill_ae[%0d] got %b exp %b", i, almostEmpty, i < 2); end
         checks++; if (almostFull !== (i >= 5)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almostFull, i >= 5); end
         checks++; if (full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 7); end
      end
      push(32'hDEAD);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b exp 1", overflow); end
      checks++; if (count !== 4'd8)    begin errors++; $display("FAIL fill_ovf_count got %0d exp 8", count); end
      tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_pulse got %b exp 0", overflow); end
   endtask

   // Continues from a full FIFO holding 1,2,4..128.
   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
`ifdef FIFO_SYNC_FWFT_EN
         checks++; if (dataOut !== (32'd1 << i)) begin errors++; $display("FAIL drain_head[%0d] got %h exp %h", i, dataOut, 32'd1 << i); end
`endif
         rdEn = 1'b1;
         tick();
         rdEn = 1'b0;
`ifndef FIFO_SYNC_FWFT_EN
         checks++; if (dataOut !== (32'd1 << i)) begin errors++; $display("FAIL drain_dout[%0d] got %h exp %h", i, dataOut, 32'd1 << i); end
`endif
         checks++; if (count !== 4'(7 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 7 - i); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_unf got %b exp 1", underflow); end
`ifdef FIFO_SYNC_FWFT_EN
      checks++; if (dataOut !== 32'd0)   begin errors++; $display("FAIL drain_hold got %h exp 0", dataOut); end
`else
      checks++; if (dataOut !== 32'd128) begin errors++; $display("FAIL drain_hold got %h exp 80", dataOut); end
`endif
      tick();
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_unf_pulse got %b exp 0", underflow); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 4; i++) push(32'd10 + i);
      for (int i = 0; i < 3; i++) begin
`ifdef FIFO_SYNC_FWFT_EN
         checks++; if (dataOut !== 32'(10 + i)) begin errors++; $display("FAIL simul_head[%0d] got %0d exp %0d", i, dataOut, 10 + i); end
`endif
         wrEn = 1'b1; rdEn = 1'b1; dataIn = 32'd14 + i;
         tick();
`ifndef FIFO_SYNC_FWFT_EN
         checks++; if (dataOut !== 32'(10 + i)) begin errors++; $display("FAIL simul_dout[%0d] got %0d exp %0d", i, dataOut, 10 + i); end
`endif
         checks++; if (count !== 4'd4) begin errors++; $display("FAIL simul_count[%0d] got %0d exp 4", i, count); end
      end
      wrEn = 1'b0;
      for (int i = 0; i < 4; i++) begin
`ifdef FIFO_SYNC_FWFT_EN
         checks++; if (dataOut !== 32'(13 + i)) begin errors++; $display("FAIL simul_order[%0d] got %0d exp %0d", i, dataOut, 13 + i); end
`endif
         tick();
`ifndef FIFO_SYNC_FWFT_EN
         checks++; if (dataOut !== 32'(13 + i)) begin errors++; $display("FAIL simul_order[%0d] got %0d exp %0d", i, dataOut, 13 + i); end
`endif
      end
      rdEn = 1'b0;
      for (int i = 0; i < 8; i++) push(32'd100 + i);
      wrEn = 1'b1; rdEn = 1'b1; dataIn = 32'hBAD;
      tick();
      wrEn = 1'b0; rdEn = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL simul_full_ovf got %b exp 1", overflow); end
      checks++; if (count !== 4'd7)    begin errors++; $display("FAIL simul_full_count got %0d exp 7", count); end
`ifndef FIFO_SYNC_FWFT_EN
      checks++; if (dataOut !== 32'd100) begin errors++; $display("FAIL simul_full_dout got %0d exp 100", dataOut); end
`endif
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         push(32'(i));
`ifdef FIFO_SYNC_FWFT_EN
         checks++; if (dataOut !== 32'(i)) begin errors++; $display("FAIL wrap_head[%0d] got %0d exp %0d", i, dataOut, i); end
`endif
         rdEn = 1'b1;
         tick();
         rdEn = 1'b0;
`ifndef FIFO_SYNC_FWFT_EN
         checks++; if (dataOut !== 32'(i)) begin errors++; $display("FAIL wrap_dout[%0d] got %0d exp %0d", i, dataOut, i); end
`endif
      end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) push(32'd200 + i);
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      push(32'd205);
      checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", count); end
      rst = 1'b1; wrEn = 1'b1; rdEn = 1'b1; dataIn = 32'hFFFF;
      tick();
      rst = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
      checks++; if (count !== 4'd0)    begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
      checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL mid_dout got %h exp 0", dataOut); end
      push(32'h55);
`ifdef FIFO_SYNC_FWFT_EN
      checks++; if (dataOut !== 32'h55) begin errors++; $display("FAIL mid_first got %h exp 55", dataOut); end
`endif
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
`ifndef FIFO_SYNC_FWFT_EN
      checks++; if (dataOut !== 32'h55) begin errors++; $display("FAIL mid_first got %h exp 55", dataOut); end
`endif
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_post_empty got %b exp 1", empty); end
   endtask

`ifdef FIFO_SYNC_FWFT_EN
   task automatic test_fwft();
      do_reset();
      push(32'hA5);
      checks++; if (dataOut !== 32'hA5) begin errors++; $display("FAIL fwft_show got %h exp a5", dataOut); end
      checks++; if (empty !== 1'b0)     begin errors++; $display("FAIL fwft_nonempty got %b exp 0", empty); end
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL fwft_empty got %b exp 1", empty); end
      checks++; if (dataOut !== 32'd0)  begin errors++; $display("FAIL fwft_zero got %h exp 0", dataOut); end
   endtask
`endif

   initial begin
      rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; dataIn = '0;
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_wrap();
      test_reset_mid();
`ifdef FIFO_SYNC_FWFT_EN
      test_fwft();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
